// File: rtl/play_serial_receiver.sv
// 7E2 serial receiver that packs four characters into a 28-bit word,
// with per-character/per-word strobes and error/timeout pulses.
module play_serial_receiver #(
    parameter int CLKS_PER_BIT = 434,
    parameter int TIMEOUT_BITS = 40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        serial,
    output logic [27:0] palavra,
    output logic        pronto,
    output logic [6:0]  dado_char,
    output logic        char_pronto,
    output logic [1:0]  num_chars,
    output logic        erro_paridade,
    output logic        erro_frame,
    output logic        timeout
);

    localparam int TW       = $clog2(CLKS_PER_BIT);
    localparam int IDLE_MAX = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int IW       = $clog2(IDLE_MAX);

    localparam logic [TW-1:0] HALF_END = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] BIT_END  = TW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDLE_END = IW'(IDLE_MAX - 1);

    typedef enum logic [2:0] {
        ESPERA, START, DADOS, PARIDADE, STOP1, STOP2, ARMAZENA
    } state_t;

    state_t        state_q, state_d;
    logic          rx_meta, rx_s;
    logic [TW-1:0] timer_q;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [6:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic          frm_q, frm_d;
    logic          armed_q;
    logic [IW-1:0] idle_q, idle_d;
    logic [20:0]   buf_q, buf_d;
    logic          tick;

    logic [27:0] palavra_d;
    logic [6:0]  dado_d;
    logic [1:0]  nc_d;
    logic        pronto_d, cp_d, perr_d, ferr_d, to_d;

    assign tick = (state_q == START) ? (timer_q == HALF_END)
                                     : (timer_q == BIT_END);

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        par_d     = par_q;
        frm_d     = frm_q;
        idle_d    = '0;
        buf_d     = buf_q;
        palavra_d = palavra;
        dado_d    = dado_char;
        nc_d      = num_chars;
        pronto_d  = 1'b0;
        cp_d      = 1'b0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        to_d      = 1'b0;
        unique case (state_q)
            ESPERA: begin
                // A start edge in the same cycle beats the timeout
                if (!rx_s && armed_q) begin
                    state_d = START;
                end else if (num_chars != 2'd0) begin
                    if (idle_q == IDLE_END) begin
                        to_d = 1'b1;
                        nc_d = 2'd0;
                    end else begin
                        idle_d = idle_q + IW'(1);
                    end
                end
            end
            START: begin
                if (tick) begin
                    if (rx_s) begin
                        state_d = ESPERA;
                    end else begin
                        state_d   = DADOS;
                        bit_idx_d = 3'd0;
                    end
                end
            end
            DADOS: begin
                if (tick) begin
                    shift_d   = {rx_s, shift_q[6:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd6) state_d = PARIDADE;
                end
            end
            PARIDADE: begin
                if (tick) begin
                    par_d   = rx_s ^ (^shift_q);
                    frm_d   = 1'b0;
                    state_d = STOP1;
                end
            end
            STOP1: begin
                if (tick) begin
                    frm_d   = ~rx_s;
                    state_d = STOP2;
                end
            end
            STOP2: begin
                if (tick) begin
                    if (!rx_s) frm_d = 1'b1;
                    state_d = ARMAZENA;
                end
            end
            ARMAZENA: begin
                state_d = ESPERA;
                if (frm_q) begin
                    ferr_d = 1'b1;
                    nc_d   = 2'd0;
                end else if (par_q) begin
                    perr_d = 1'b1;
                    nc_d   = 2'd0;
                end else begin
                    dado_d = shift_q;
                    cp_d   = 1'b1;
                    nc_d   = num_chars + 2'd1;
                    unique case (num_chars)
                        2'd0: buf_d[6:0]   = shift_q;
                        2'd1: buf_d[13:7]  = shift_q;
                        2'd2: buf_d[20:14] = shift_q;
                        2'd3: begin
                            palavra_d = {shift_q, buf_q};
                            pronto_d  = 1'b1;
                        end
                    endcase
                end
            end
            default: state_d = ESPERA;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta       <= 1'b1;
            rx_s          <= 1'b1;
            state_q       <= ESPERA;
            timer_q       <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            par_q         <= 1'b0;
            frm_q         <= 1'b0;
            armed_q       <= 1'b0;
            idle_q        <= '0;
            buf_q         <= '0;
            palavra       <= '0;
            dado_char     <= '0;
            num_chars     <= '0;
            pronto        <= 1'b0;
            char_pronto   <= 1'b0;
            erro_paridade <= 1'b0;
            erro_frame    <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            rx_meta       <= serial;
            rx_s          <= rx_meta;
            state_q       <= state_d;
            timer_q       <= (state_d != state_q) ? '0 : timer_q + TW'(1);
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            par_q         <= par_d;
            frm_q         <= frm_d;
            // Re-arm only after the line has been seen high while idle
            armed_q       <= (state_q == ESPERA) && rx_s;
            idle_q        <= idle_d;
            buf_q         <= buf_d;
            palavra       <= palavra_d;
            dado_char     <= dado_d;
            num_chars     <= nc_d;
            pronto        <= pronto_d;
            char_pronto   <= cp_d;
            erro_paridade <= perr_d;
            erro_frame    <= ferr_d;
            timeout       <= to_d;
        end
    end

endmodule
